cam_frame_capture: RTL and testbench
====================================

# cam_frame_capture

Camera capture stage that fills the 160x148 RGB444 frame buffer scanned out by the VGA display stage. It samples an 8-bit RGB565 camera bus (vsync/href/data), pairs bytes into pixels, converts them to 12-bit RGB444, decimates and crops the 640x480 source to the buffer geometry, and issues single-cycle write strobes with linear addresses. Its write port connects to the buffer's write side; the display stage reads the same buffer through its 15-bit read address.

## Interface
- SRC_W, 640, source active pixels per line
- SRC_H, 480, source active lines per frame
- H_DECIM, 4, keep 1 of every H_DECIM source pixels (first of each group)
- V_DECIM, 3, keep 1 of every V_DECIM source lines (first of each group)
- IMG_W, 160, stored pixels per row; kept pixels beyond this are dropped
- IMG_H, 148, stored rows; kept lines beyond this are dropped
- ADDR_W, 15, write address width; IMG_W*IMG_H must be at most 2^ADDR_W

- clk_in  in  1  clock; camera bus synchronous to it (clk_in is the camera pixel clock)
- reset  in  1  synchronous, active-low
- capture_en  in  1  level; enables capture of subsequent frames
- cam_vsync  in  1  high during vertical blanking
- cam_href  in  1  high while line bytes are valid
- cam_data  in  8  RGB565 byte stream, high byte first
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  ADDR_W  row*IMG_W + col
- wr_data  out  12  {R[3:0],G[3:0],B[3:0]}
- frame_done  out  1  one-cycle pulse at the end of each captured frame
- busy  out  1  high in CAPTURE
- frame_count  out  8  captured frames, wraps 255->0

## Operation
- Input register stage: cam_vsync, cam_href, and cam_data are registered once. All logic uses the registered copies. vsync_q/href_q hold the previous values for edge detection.
- States:
  - IDLE: stays here while capture_en=0. Goes to WAIT_SOF when capture_en=1.
  - WAIT_SOF: waits for a vsync falling edge, then goes to CAPTURE. On entry to CAPTURE, clears the line, pixel, sub, and address counters.
  - CAPTURE: on a vsync rising edge, pulses frame_done, increments frame_count, and goes to WAIT_SOF if capture_en=1, otherwise IDLE.
- capture_en=0 mid-frame never aborts; the current frame completes normally.
- Byte pairing:
  - byte_phase toggles on each href-high cycle and is forced to 0 while href is low.
  - Phase 0 latches the high byte; phase 1 completes the pixel.
  - A dangling odd byte at the href falling edge is discarded.
- Colour conversion (hi, lo bytes): R=hi[7:4], G={hi[2:0],lo[7]}, B=lo[4:1].
- Decimation counters (no dividers):
  - hsub cycles 0..H_DECIM-1 per completed pixel.
  - vsub cycles 0..V_DECIM-1 per href falling edge.
  - col counts kept pixels; row counts kept lines. hsub and col clear at each href falling edge.
- Write condition: CAPTURE && pixel complete && hsub==0 && vsub==0 && col<IMG_W && row<IMG_H.
- Address:
  - wr_addr is a running counter that increments after each write, reset to 0 at start of frame.
  - With the defaults it ends at IMG_W*IMG_H-1 = 23679.
  - No write occurs at or beyond IMG_W*IMG_H. If a short line leaves col<IMG_W, the address still equals row*IMG_W+col, because the counter is recomputed as row*IMG_W at the start of each kept line.
- Source lines beyond SRC_H or pixels beyond SRC_W are ignored; the counters saturate.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, busy=0, frame_count=0, state=IDLE. All input registers and counters clear to 0.
- Reset asserted mid-frame: wr_en is 0 on the next cycle. After release the block waits for a full new vsync falling edge and never resumes a partial frame.
- Latency: the low byte is present at clock edge k. wr_en, wr_addr, and wr_data are registered and valid in the cycle after edge k+1 (2 cycles).
- wr_en is high exactly 1 cycle per stored pixel. With H_DECIM>=1, writes are at least 2 cycles apart.
- frame_done is high 1 cycle, 2 cycles after the vsync rise at the pins. frame_count updates in the same cycle.
- busy is high from the cycle after the vsync fall detection until the cycle of frame_done, inclusive.
- Simultaneous pixel completion and vsync rise: the pixel is written in the same cycle frame_done asserts.

## Test plan
- Single pixel, decimation 1 (H_DECIM=V_DECIM=1): bytes 0xF8,0x1F -> wr_data=0x0F0F-equivalent 12'hF0F at addr 0. Bytes 0x07,0xE0 -> 12'h0F0 at addr 1.
- Full 640x480 frame, defaults:
  - Exactly 23680 wr_en pulses, addresses 0..23679 strictly incrementing.
  - Source line 3 pixel 0 -> addr 160; source line 0 pixel 4 -> addr 1; lines 1 and 2 produce no writes.
  - One frame_done pulse; frame_count=1.
- Crop: source lines 444..479 produce no writes. wr_addr never exceeds 23679.
- capture_en dropped at line 200: the frame completes (23680 writes), the state returns to IDLE, and the next frame produces no writes.
- Reset low for 1 cycle at line 100: wr_en=0 the next cycle. The remainder of that frame produces no writes. The next frame starts at addr 0.
- Odd byte count (641 bytes on a line): the trailing byte is discarded. The next line's first pixel pairs correctly, e.g. 0x07,0xE0 -> 12'h0F0.

Source files
------------

// File: rtl/cam_frame_capture.sv
// cam_frame_capture: turns an 8-bit RGB565 camera byte stream into decimated,
// cropped RGB444 pixels and writes them into a linear frame buffer.
//
// Write port: wr_en is a single-cycle strobe with no back-pressure. wr_addr
// and wr_data are meaningful only in a cycle where wr_en is high, and the
// buffer must accept the write in that cycle.
module cam_frame_capture #(
  parameter int SRC_W   = 640,
  parameter int SRC_H   = 480,
  parameter int H_DECIM = 4,
  parameter int V_DECIM = 3,
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 148,
  parameter int ADDR_W  = 15
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic [7:0]        frame_count,
  output logic [1:0]        state_dbg
);

  localparam int PX_W  = $clog2(SRC_W + 1);
  localparam int LN_W  = $clog2(SRC_H + 1);
  localparam int HS_W  = $clog2(H_DECIM + 1);
  localparam int VS_W  = $clog2(V_DECIM + 1);
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);

  localparam logic [PX_W-1:0]   SRC_W_L  = PX_W'(SRC_W);
  localparam logic [LN_W-1:0]   SRC_H_L  = LN_W'(SRC_H);
  localparam logic [HS_W-1:0]   HS_LAST  = HS_W'(H_DECIM - 1);
  localparam logic [VS_W-1:0]   VS_LAST  = VS_W'(V_DECIM - 1);
  localparam logic [COL_W-1:0]  IMG_W_C  = COL_W'(IMG_W);
  localparam logic [ROW_W-1:0]  IMG_H_R  = ROW_W'(IMG_H);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  state_t state;

  // Registered camera bus and previous values for edge detection
  logic       vsync_r, href_r, vsync_q, href_q;
  logic [7:0] data_r;

  // Byte pairing
  logic       byte_phase;
  logic [6:0] hi_bits;      // hi byte without bit 3, which RGB444 never uses

  // Position tracking within the source frame and the stored image
  logic [PX_W-1:0]   src_px;
  logic [LN_W-1:0]   src_line;
  logic [HS_W-1:0]   hsub;
  logic [VS_W-1:0]   vsub;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] wr_ptr;

  logic        vsync_fall, vsync_rise, href_fall;
  logic        px_done, px_valid, do_write;
  logic [11:0] px_rgb;

  assign vsync_fall = vsync_q & ~vsync_r;
  assign vsync_rise = ~vsync_q & vsync_r;
  assign href_fall  = href_q & ~href_r;

  // A pixel completes on the second byte of a pair; pixels past the source
  // geometry are ignored entirely
  assign px_done  = href_r & byte_phase;
  assign px_valid = px_done && (src_px < SRC_W_L) && (src_line < SRC_H_L);
  assign do_write = (state == CAPTURE) && px_valid && (hsub == '0) &&
                    (vsub == '0) && (col < IMG_W_C) && (row < IMG_H_R);

  // RGB565 {hi,lo} -> RGB444: R=hi[7:4], G={hi[2:0],lo[7]}, B=lo[4:1]
  assign px_rgb = {hi_bits[6:3], hi_bits[2:0], data_r[7], data_r[4:1]};

  assign state_dbg = state;

  // Input register stage and one-cycle history for edge detection
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
      data_r  <= 8'd0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_r <= cam_vsync;
      href_r  <= cam_href;
      data_r  <= cam_data;
      vsync_q <= vsync_r;
      href_q  <= href_r;
    end
  end

  // Pair bytes: phase 0 holds the high byte; a dangling odd byte dies with href
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      byte_phase <= 1'b0;
      hi_bits    <= 7'd0;
    end else if (!href_r) begin
      byte_phase <= 1'b0;
    end else begin
      byte_phase <= ~byte_phase;
      if (!byte_phase) hi_bits <= {data_r[7:4], data_r[2:0]};
    end
  end

  // Decimation, crop and address counters; restarted on each start of frame
  always_ff @(posedge clk_in) begin
    if (!reset || (state == WAIT_SOF && vsync_fall)) begin
      src_px   <= '0;
      src_line <= '0;
      hsub     <= '0;
      vsub     <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      wr_ptr   <= '0;
    end else if (state == CAPTURE) begin
      if (px_valid) begin
        src_px <= src_px + 1'b1;
        hsub   <= (hsub == HS_LAST) ? '0 : hsub + 1'b1;
        if (hsub == '0 && col < IMG_W_C) col <= col + 1'b1;
      end
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (href_fall) begin
        src_px <= '0;
        hsub   <= '0;
        col    <= '0;
        if (src_line < SRC_H_L) begin
          src_line <= src_line + 1'b1;
          vsub     <= (vsub == VS_LAST) ? '0 : vsub + 1'b1;
          // Re-derive the next row's start so short lines cannot skew addresses
          if (vsub == '0 && row < IMG_H_R) begin
            row      <= row + 1'b1;
            row_base <= row_base + IMG_W_A;
            wr_ptr   <= row_base + IMG_W_A;
          end
        end
      end
    end
  end

  // Frame FSM with registered write port, frame_done, busy and frame_count
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state       <= IDLE;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 12'd0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      wr_en      <= do_write;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      if (do_write) begin
        wr_addr <= wr_ptr;
        wr_data <= px_rgb;
      end
      case (state)
        IDLE: begin
          if (capture_en) state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (vsync_fall) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          // busy stays up through the frame_done cycle
          busy <= 1'b1;
          if (vsync_rise) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
            state       <= capture_en ? WAIT_SOF : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Bench for cam_frame_capture on a reduced geometry: 12x15 source, keep 1/2
// pixels and 1/3 lines, 8x4 stored image (short rows of 6 pixels, vertical crop).
module tb_cam_frame_capture;

  localparam int SW = 12;
  localparam int SH = 15;
  localparam int HD = 2;
  localparam int VD = 3;
  localparam int IW = 8;
  localparam int IH = 4;
  localparam int AW = 5;
  localparam int W  = AW + 12;

  logic          clk_in;
  logic          reset;
  logic          capture_en;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          frame_done;
  logic          busy;
  logic [7:0]    frame_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_fc_q[$];
  logic         prev_wr = 1'b0;

  // Directed pixels: source line, pixel, bytes, hand-computed address and colour
  int          d_line[5] = '{0, 0, 3, 6, 9};
  int          d_px[5]   = '{0, 2, 0, 4, 10};
  logic [7:0]  d_hi[5]   = '{8'hF8, 8'h07, 8'h07, 8'hA5, 8'hFF};
  logic [7:0]  d_lo[5]   = '{8'h1F, 8'hE0, 8'hE0, 8'h5A, 8'hFF};
  logic [AW-1:0] d_addr[5] = '{5'd0, 5'd1, 5'd8, 5'd18, 5'd29};
  logic [11:0] d_data[5] = '{12'hF0F, 12'h0F0, 12'h0F0, 12'hAAD, 12'hFFF};

  cam_frame_capture #(
    .SRC_W(SW), .SRC_H(SH), .H_DECIM(HD), .V_DECIM(VD),
    .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .capture_en(capture_en),
    .cam_vsync(cam_vsync),
    .cam_href(cam_href),
    .cam_data(cam_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .busy(busy),
    .frame_count(frame_count),
    .state_dbg(state_dbg)
  );

  // Clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Bytes for a source pixel: directed table first, otherwise a fixed pattern
  task automatic pixel_bytes(input int l, input int j, output logic [7:0] hi,
                             output logic [7:0] lo, output int idx);
    idx = -1;
    hi  = 8'((l * 37 + j * 11 + 5) & 255);
    lo  = 8'((l * 13 + j * 29 + 91) & 255);
    for (int k = 0; k < 5; k++) begin
      if (d_line[k] == l && d_px[k] == j) begin
        idx = k;
        hi  = d_hi[k];
        lo  = d_lo[k];
      end
    end
  endtask

  function automatic bit model_kept(input int l, input int j);
    return (l < SH) && (j < SW) && (l % VD == 0) && (j % HD == 0) &&
           (l / VD < IH) && (j / HD < IW);
  endfunction

  function automatic logic [W-1:0] model_exp(input int l, input int j,
                                             input logic [7:0] hi, input logic [7:0] lo);
    int a;
    a = (l / VD) * IW + j / HD;
    return {AW'(a), hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

  // Drive one line; line 2 carries an odd byte count, lines 0 and 9 overrun SRC_W
  task automatic send_line(input int l, input bit cap);
    int n;
    int idx;
    logic [7:0] hi, lo;
    n = (l == 2) ? 7 : ((l == 0 || l == 9) ? 32 : 24);
    for (int b = 0; b < n; b++) begin
      pixel_bytes(l, b / 2, hi, lo, idx);
      cam_href = 1'b1;
      if (b % 2 == 0) begin
        cam_data = hi;
      end else begin
        cam_data = lo;
        if (cap) begin
          if (idx >= 0) exp_q.push_back({d_addr[idx], d_data[idx]});
          else if (model_kept(l, b / 2)) exp_q.push_back(model_exp(l, b / 2, hi, lo));
        end
      end
      tick();
    end
    cam_href = 1'b0;
  endtask

  // One 16-line frame (line 15 lies beyond SRC_H); optional reset or enable drop
  task automatic send_frame(input int rst_line, input int drop_line, input bit cap);
    bit cap_now;
    cap_now   = cap;
    cam_href  = 1'b0;
    cam_vsync = 1'b1;
    repeat (6) tick();
    cam_vsync = 1'b0;
    repeat (4) tick();
    chk("busy_in_frame", 32'(busy), 32'(cap));
    for (int l = 0; l < 16; l++) begin
      if (l == drop_line) capture_en = 1'b0;
      if (l == rst_line) begin
        reset = 1'b0;
        tick();
        chk("wr_en_after_reset", 32'(wr_en), 32'd0);
        chk("fc_after_reset", 32'(frame_count), 32'd0);
        chk("state_after_reset", 32'(state_dbg), 32'd0);
        reset   = 1'b1;
        cap_now = 1'b0;
      end
      send_line(l, cap_now);
      repeat (4) tick();
    end
    cam_vsync = 1'b1;
    repeat (6) tick();
  endtask

  // Monitor: pops the scoreboard on every write strobe and frame_done pulse
  always @(negedge clk_in) begin
    logic [W-1:0] e;
    logic [7:0]   f;
    if (wr_en === 1'b1) begin
      checks++;
      if (prev_wr) begin
        errors++;
        $display("FAIL wr_spacing got back-to-back strobes expected gap");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got addr %0d data %03h expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL wr_pixel got addr %0d data %03h expected addr %0d data %03h",
                   wr_addr, wr_data, e[W-1:12], e[11:0]);
        end
      end
    end
    prev_wr = (wr_en === 1'b1);
    if (frame_done === 1'b1) begin
      checks++;
      if (exp_fc_q.size() == 0) begin
        errors++;
        $display("FAIL frame_done_unexpected got pulse with count %0d expected none", frame_count);
      end else begin
        f = exp_fc_q.pop_front();
        if (frame_count !== f) begin
          errors++;
          $display("FAIL frame_count got %0d expected %0d", frame_count, f);
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_at_done got %b expected 1", busy);
      end
    end
  end

  // Stimulus
  initial begin
    reset      = 1'b0;
    capture_en = 1'b0;
    cam_vsync  = 1'b0;
    cam_href   = 1'b0;
    cam_data   = 8'd0;
    repeat (3) tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_hold", 32'(state_dbg), 32'd0);
    capture_en = 1'b1;
    repeat (2) tick();
    chk("wait_sof", 32'(state_dbg), 32'd1);

    // Frame A: normal capture with crop, overrun lines and an odd-byte line
    exp_fc_q.push_back(8'd1);
    send_frame(-1, -1, 1'b1);
    chk("a_writes_left", 32'(exp_q.size()), 32'd0);
    chk("a_done_left", 32'(exp_fc_q.size()), 32'd0);
    chk("a_state", 32'(state_dbg), 32'd1);

    // Frame B: enable dropped at line 5, frame still completes
    exp_fc_q.push_back(8'd2);
    send_frame(-1, 5, 1'b1);
    chk("b_writes_left", 32'(exp_q.size()), 32'd0);
    chk("b_done_left", 32'(exp_fc_q.size()), 32'd0);
    chk("b_state_idle", 32'(state_dbg), 32'd0);
    chk("b_busy", 32'(busy), 32'd0);

    // Frame C: capture disabled, nothing written
    send_frame(-1, -1, 1'b0);
    chk("c_writes_left", 32'(exp_q.size()), 32'd0);
    chk("c_frame_count", 32'(frame_count), 32'd2);
    chk("c_state_idle", 32'(state_dbg), 32'd0);

    // Frame D: reset pulse at line 7, rest of frame must not be written
    capture_en = 1'b1;
    repeat (2) tick();
    send_frame(7, -1, 1'b1);
    chk("d_writes_left", 32'(exp_q.size()), 32'd0);
    chk("d_frame_count", 32'(frame_count), 32'd0);
    chk("d_state", 32'(state_dbg), 32'd1);

    // Frame E: fresh capture restarts at address 0
    exp_fc_q.push_back(8'd1);
    send_frame(-1, -1, 1'b1);
    chk("e_writes_left", 32'(exp_q.size()), 32'd0);
    chk("e_done_left", 32'(exp_fc_q.size()), 32'd0);
    chk("e_frame_count", 32'(frame_count), 32'd1);

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
